// File: rtl/vecmac_stream_if.sv
// Beat and result handshake bundle for the vector multiply-accumulate unit.
// The master side supplies beats and consumes results; the slave side is the unit.
interface vecmac_stream_if #(
  parameter int LANES       = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int ACC_SEL_W   = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;
  logic [LANES-1:0]            in_mask;
  logic                        in_signed;
  logic [ACC_SEL_W-1:0]        in_acc_sel;
  logic                        in_first;
  logic                        in_last;
  logic                        acc_clear;
  logic                        out_valid;
  logic                        out_ready;
  logic [ACCUM_WIDTH-1:0]      out_result;
  logic [ACC_SEL_W-1:0]        out_acc_sel;
  logic                        out_sat;

  modport master (
    output in_valid, in_a, in_b, in_mask, in_signed, in_acc_sel, in_first, in_last,
    output acc_clear, out_ready,
    input  in_ready, out_valid, out_result, out_acc_sel, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mask, in_signed, in_acc_sel, in_first, in_last,
    input  acc_clear, out_ready,
    output in_ready, out_valid, out_result, out_acc_sel, out_sat
  );
endinterface

// File: rtl/vecmac_stream_unit.sv
// Streaming vector MAC: per-lane products, adder-tree lane sum, then a saturating
// read-modify-write into one of NUM_ACC accumulator banks; emits on the last beat.
module vecmac_stream_unit #(
  parameter int LANES       = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int NUM_ACC     = 4,
  parameter int ACC_SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input logic           clk,
  input logic           rst,
  vecmac_stream_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCUM_WIDTH;
  // one spare bit lets unsigned products share the signed lane datapath
  localparam int PW = 2*DW + 1;

  // Both return {clamped, value} from an AW+1 bit exact sum.
  function automatic logic [AW:0] sat_signed(input logic [AW:0] wide);
    logic [AW:0] r;
    if (wide[AW] != wide[AW-1]) r = {1'b1, wide[AW], {(AW-1){~wide[AW]}}};
    else                        r = {1'b0, wide[AW-1:0]};
    return r;
  endfunction

  function automatic logic [AW:0] sat_unsigned(input logic [AW:0] wide);
    logic [AW:0] r;
    if (wide[AW]) r = {1'b1, {AW{1'b1}}};
    else          r = {1'b0, wide[AW-1:0]};
    return r;
  endfunction

  logic advance;
  logic out_valid_r, out_sat_r;
  logic [AW-1:0] out_result_r;
  logic [ACC_SEL_W-1:0] out_sel_r;

  assign advance          = !out_valid_r || bus.out_ready;
  assign bus.in_ready     = advance;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_result   = out_result_r;
  assign bus.out_acc_sel  = out_sel_r;
  assign bus.out_sat      = out_sat_r;

  // ---- stage 1: lane products ----
  logic signed [PW-1:0] prod_c [LANES];
  logic signed [PW-1:0] prod_p1 [LANES];
  logic vld_p1, sgn_p1, first_p1, last_p1;
  logic [ACC_SEL_W-1:0] sel_p1;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = '0;
      if (bus.in_mask[i]) begin
        if (bus.in_signed)
          prod_c[i] = PW'($signed(bus.in_a[i*DW +: DW])) * PW'($signed(bus.in_b[i*DW +: DW]));
        else
          prod_c[i] = $signed(PW'(bus.in_a[i*DW +: DW])) * $signed(PW'(bus.in_b[i*DW +: DW]));
      end
    end
  end

  // ---- stage 2: lane sum ----
  logic signed [AW-1:0] sum_c;
  logic signed [AW-1:0] sum_p2;
  logic vld_p2, sgn_p2, first_p2, last_p2;
  logic [ACC_SEL_W-1:0] sel_p2;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + AW'(prod_p1[i]);
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < LANES; i++) prod_p1[i] <= prod_c[i];
      sgn_p1   <= bus.in_signed;
      first_p1 <= bus.in_first;
      last_p1  <= bus.in_last;
      sel_p1   <= bus.in_acc_sel;
      sum_p2   <= sum_c;
      sgn_p2   <= sgn_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      sel_p2   <= sel_p1;
    end
  end

  // ---- stage 3: bank read-modify-write and output register ----
  logic [AW-1:0] bank [NUM_ACC];
  logic [NUM_ACC-1:0] sat_flag;
  logic fresh_c, sticky_c, clamp_c;
  logic [AW-1:0] base_c, new_c;
  logic [AW:0] wide_c, sat_c;

  always_comb begin
    fresh_c  = first_p2 | bus.acc_clear;
    base_c   = fresh_c ? '0 : bank[sel_p2];
    sticky_c = fresh_c ? 1'b0 : sat_flag[sel_p2];
    wide_c   = '0;
    sat_c    = '0;
    if (sgn_p2) begin
      wide_c = {base_c[AW-1], base_c} + {sum_p2[AW-1], sum_p2};
      sat_c  = sat_signed(wide_c);
    end else begin
      wide_c = {1'b0, base_c} + {1'b0, sum_p2};
      sat_c  = sat_unsigned(wide_c);
    end
    clamp_c = sat_c[AW];
    new_c   = sat_c[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      out_valid_r  <= 1'b0;
      out_result_r <= '0;
      out_sel_r    <= '0;
      out_sat_r    <= 1'b0;
      for (int k = 0; k < NUM_ACC; k++) bank[k] <= '0;
      sat_flag     <= '0;
    end else begin
      if (advance) begin
        vld_p1      <= bus.in_valid;
        vld_p2      <= vld_p1;
        out_valid_r <= vld_p2 && last_p2;
        if (vld_p2 && last_p2) begin
          out_result_r <= new_c;
          out_sel_r    <= sel_p2;
          out_sat_r    <= sticky_c | clamp_c;
        end
      end
      if (bus.acc_clear) begin
        for (int k = 0; k < NUM_ACC; k++) bank[k] <= '0;
        sat_flag <= '0;
      end
      // placed after the clear so an S3 beat in a clear cycle still lands
      if (advance && vld_p2) begin
        bank[sel_p2]     <= new_c;
        sat_flag[sel_p2] <= sticky_c | clamp_c;
      end
    end
  end
endmodule

// File: tb/tb_vecmac_stream_unit.sv
// Randomized and directed bench for vecmac_stream_unit against an integer reference model.
module tb_vecmac_stream_unit;
  localparam int LANES = 4, DW = 8, AW = 20, NACC = 4, SW = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mask;
    logic        sgn;
    logic [1:0]  sel;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [AW-1:0] res;
    logic [1:0]    sel;
    logic          sat;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vecmac_stream_if #(.LANES(LANES), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .ACC_SEL_W(SW)) bus ();

  vecmac_stream_unit #(.LANES(LANES), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .NUM_ACC(NACC),
                       .ACC_SEL_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  res_t exp_q[$];
  res_t got_q[$];
  longint m_bank[NACC];
  bit m_sticky[NACC];
  bit done;

  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready)
      got_q.push_back({bus.out_result, bus.out_acc_sel, bus.out_sat});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int k = 0; k < NACC; k++) begin m_bank[k] = 0; m_sticky[k] = 0; end
  endfunction

  // Reference: exact integer dot product, then clamp into the beat's range.
  function automatic void model_apply(beat_t bt);
    longint s, base, v, lo, hi;
    logic [7:0] ai, bi;
    bit c;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      ai = bt.a[i*8 +: 8];
      bi = bt.b[i*8 +: 8];
      if (bt.mask[i]) begin
        if (bt.sgn) s += longint'($signed(ai)) * longint'($signed(bi));
        else        s += longint'(ai) * longint'(bi);
      end
    end
    if (bt.first) begin
      base = 0;
      m_sticky[bt.sel] = 0;
    end else if (bt.sgn && m_bank[bt.sel] >= (64'sd1 << 19)) base = m_bank[bt.sel] - (64'sd1 << 20);
    else base = m_bank[bt.sel];
    if (bt.sgn) begin lo = -(64'sd1 << 19); hi = (64'sd1 << 19) - 1; end
    else        begin lo = 0;               hi = (64'sd1 << 20) - 1; end
    v = base + s;
    c = 0;
    if (v > hi) begin v = hi; c = 1; end
    if (v < lo) begin v = lo; c = 1; end
    m_bank[bt.sel] = (v < 0) ? v + (64'sd1 << 20) : v;
    m_sticky[bt.sel] = m_sticky[bt.sel] | c;
    if (bt.last) exp_q.push_back({AW'(m_bank[bt.sel]), bt.sel, m_sticky[bt.sel]});
  endfunction

  function automatic beat_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] m, logic s,
                               logic [1:0] sel, logic f, logic l);
    beat_t bt;
    bt.a = a; bt.b = b; bt.mask = m; bt.sgn = s; bt.sel = sel; bt.first = f; bt.last = l;
    return bt;
  endfunction

  function automatic beat_t rnd_beat(bit last_always);
    beat_t bt;
    bt.a = $urandom; bt.b = $urandom;
    bt.mask = 4'($urandom_range(0, 15));
    bt.sgn = 1'($urandom_range(0, 1));
    bt.sel = 2'($urandom_range(0, 3));
    bt.first = last_always || ($urandom_range(0, 3) == 0);
    bt.last = last_always || ($urandom_range(0, 2) == 0);
    return bt;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input beat_t bt);
    int k;
    bus.in_valid = 1'b1; bus.in_a = bt.a; bus.in_b = bt.b; bus.in_mask = bt.mask;
    bus.in_signed = bt.sgn; bus.in_acc_sel = bt.sel; bus.in_first = bt.first; bus.in_last = bt.last;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin model_apply(bt); break; end
      k++;
      if (k > 200) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout in_ready stuck at %0b, required 1", bus.in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 400) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_result !== '0) begin n_fail++; $display("FAIL reset_out_result got %0h exp 0", bus.out_result); end
    n_checks++; if (bus.out_acc_sel !== '0) begin n_fail++; $display("FAIL reset_out_acc_sel got %0d exp 0", bus.out_acc_sel); end
    n_checks++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got %0b exp 0", bus.out_sat); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_unsigned_single();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b1;
    send(mk({4{8'd3}}, {4{8'd5}}, 4'hF, 1'b0, 2'd0, 1'b1, 1'b1));
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early out_valid got %0b exp 0", bus.out_valid); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency out_valid got %0b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_result !== 20'd60) begin n_fail++; $display("FAIL unsigned_value got %0d exp 60", bus.out_result); end
    drain(exp_q.size());
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL unsigned_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL unsigned[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_signed_sparse();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    send(mk({4{8'h80}}, {4{8'h80}}, 4'b0111, 1'b1, 2'd0, 1'b1, 1'b1));
    send(mk({4{8'hFE}}, {4{8'd3}}, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1));
    drain(exp_q.size());
    n_checks++; if (got_q.size() < 1 || got_q[0].res !== 20'd49152) begin n_fail++; $display("FAIL signed_sparse_value got %0d exp 49152", got_q.size() > 0 ? got_q[0].res : 0); end
    n_checks++; if (got_q.size() < 2 || got_q[1].res !== 20'hFFFE8) begin n_fail++; $display("FAIL signed_neg_value got %0h exp fffe8", got_q.size() > 1 ? got_q[1].res : 0); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL signed_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL signed[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s10, s7, ones;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    s10 = {8'd4, 8'd3, 8'd2, 8'd1}; s7 = {8'd0, 8'd4, 8'd2, 8'd1}; ones = {4{8'd1}};
    send(mk(s10, ones, 4'hF, 1'b0, 2'd1, 1'b1, 1'b0));
    send(mk(s7,  ones, 4'hF, 1'b0, 2'd2, 1'b1, 1'b0));
    send(mk(s10, ones, 4'hF, 1'b0, 2'd1, 1'b0, 1'b0));
    send(mk(s7,  ones, 4'hF, 1'b0, 2'd2, 1'b0, 1'b1));
    send(mk(s10, ones, 4'hF, 1'b0, 2'd1, 1'b0, 1'b1));
    drain(exp_q.size());
    n_checks++; if (got_q.size() < 2 || got_q[0] !== {20'd14, 2'd2, 1'b0} || got_q[1] !== {20'd30, 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL interleave_order got %0d results, required bank2=14 then bank1=30", got_q.size()); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL interleave_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL interleave[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_saturation();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 9; i++)
      send(mk({4{8'h80}}, {4{8'h80}}, 4'hF, 1'b1, 2'd3, i == 0, i == 8));
    send(mk({8'd2, 8'd1, 8'd1, 8'd1}, {4{8'd1}}, 4'hF, 1'b1, 2'd3, 1'b1, 1'b1));
    for (int i = 0; i < 5; i++)
      send(mk({4{8'hFF}}, {4{8'hFF}}, 4'hF, 1'b0, 2'd2, i == 0, i == 4));
    drain(exp_q.size());
    n_checks++; if (got_q.size() < 1 || got_q[0].res !== 20'd524287 || got_q[0].sat !== 1'b1) begin n_fail++; $display("FAIL signed_clamp got %0d results, required 524287 with sat=1", got_q.size()); end
    n_checks++; if (got_q.size() < 2 || got_q[1].res !== 20'd5 || got_q[1].sat !== 1'b0) begin n_fail++; $display("FAIL sat_cleared got %0d results, required 5 with sat=0", got_q.size()); end
    n_checks++; if (got_q.size() < 3 || got_q[2].res !== 20'hFFFFF || got_q[2].sat !== 1'b1) begin n_fail++; $display("FAIL unsigned_clamp got %0d results, required fffff with sat=1", got_q.size()); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL sat_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL sat[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_backpressure();
    bit dropped, seen, stable;
    logic [AW-1:0] held;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    dropped = 0; seen = 0; stable = 1; held = '0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(rnd_beat(1'b1));
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (!bus.in_ready) dropped = 1;
          if (bus.out_valid) begin
            if (!seen) begin held = bus.out_result; seen = 1; end
            else if (bus.out_result !== held) stable = 0;
          end
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_drop got %0b exp 1", dropped); end
    n_checks++; if ((seen && stable) !== 1'b1) begin n_fail++; $display("FAIL bp_hold seen=%0b stable=%0b exp 1/1", seen, stable); end
    drain(exp_q.size());
    n_checks++;
    if (got_q.size() !== 5) begin n_fail++; $display("FAIL bp_count got %0d exp 5", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL bp[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_random();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) send(rnd_beat(1'b0));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain(exp_q.size());
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL random[%0d] got %0h/%0d/%0d exp %0h/%0d/%0d", i, got_q[i].res, got_q[i].sel, got_q[i].sat, exp_q[i].res, exp_q[i].sel, exp_q[i].sat); end
    end
  endtask

  task automatic test_acc_clear();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b1;
    send(mk({4{8'd1}}, {4{8'd1}}, 4'hF, 1'b0, 2'd0, 1'b1, 1'b0));
    send(mk({4{8'd1}}, {4{8'd1}}, 4'hF, 1'b0, 2'd0, 1'b0, 1'b0));
    model_clear();
    send(mk({8'd3, 8'd2, 8'd2, 8'd2}, {4{8'd1}}, 4'hF, 1'b0, 2'd0, 1'b0, 1'b1));
    // the last beat is two edges from the bank stage
    @(posedge clk); #1 bus.acc_clear = 1'b1;
    @(posedge clk); #1 bus.acc_clear = 1'b0;
    send(mk({8'd0, 8'd1, 8'd1, 8'd1}, {4{8'd1}}, 4'hF, 1'b0, 2'd1, 1'b0, 1'b1));
    drain(exp_q.size());
    n_checks++; if (got_q.size() < 1 || got_q[0] !== {20'd9, 2'd0, 1'b0}) begin n_fail++; $display("FAIL clear_same_cycle got %0d results, required 9 from bank 0", got_q.size()); end
    n_checks++; if (got_q.size() < 2 || got_q[1] !== {20'd3, 2'd1, 1'b0}) begin n_fail++; $display("FAIL clear_other_bank got %0d results, required 3 from bank 1", got_q.size()); end
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clear_count got %0d exp %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_beat(1'b1));
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1; bus.in_mask = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    exp_q.delete(); got_q.delete();
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_out_valid got %0b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_result !== '0 || bus.out_acc_sel !== '0 || bus.out_sat !== 1'b0) begin
      n_fail++; $display("FAIL rst_flight_outputs got %0h/%0d/%0b exp 0/0/0", bus.out_result, bus.out_acc_sel, bus.out_sat); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_flight_in_ready got %0b exp 1", bus.in_ready); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rst_flight_stale got %0d results exp 0", got_q.size()); end
    @(posedge clk); #1;
    send(mk({4{8'd2}}, {4{8'd2}}, 4'hF, 1'b0, 2'd2, 1'b1, 1'b1));
    drain(exp_q.size());
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== {20'd16, 2'd2, 1'b0}) begin n_fail++; $display("FAIL rst_flight_after got %0d results, required one 16 from bank 2", got_q.size()); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mask = '0; bus.in_signed = 1'b0;
    bus.in_acc_sel = '0; bus.in_first = 1'b0; bus.in_last = 1'b0; bus.acc_clear = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unsigned_single();
    test_signed_sparse();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_random();
    test_acc_clear();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
